// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial pattern detector.
package seq_det_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic len_legal(input logic [3:0] len, input int max_len);
    return (len != 4'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Control/data bundle between a requester (master) and the detector (slave).
interface seq_det_ctrl_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  logic               start;
  logic               abort;
  logic [MAX_LEN-1:0] pat;
  logic [3:0]         len;
  logic [CNT_W-1:0]   target;
  logic               x;
  logic               x_valid;
  logic               z;
  logic               busy;
  logic               done;
  logic               err;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output start, abort, pat, len, target, x, x_valid,
    input  z, busy, done, err, match_cnt
  );

  modport slave (
    input  start, abort, pat, len, target, x, x_valid,
    output z, busy, done, err, match_cnt
  );
endinterface

// File: rtl/seq_match_core.sv
// History shift register, fill counter and length-masked compare against the
// incoming bit; hit is a same-cycle result when en is high.
module seq_match_core #(
  parameter int MAX_LEN = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               en,
  input  logic               x,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [3:0]         len,
  output logic               hit
);
  localparam int FW = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    window = {hist_q[MAX_LEN-2:0], x};
    mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len));
    hit    = en && ((int'(fill_q) + 1) >= int'(len)) && (((window ^ pat) & mask) == '0);

    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = window;
      if (fill_q != FW'(MAX_LEN)) fill_d = fill_q + FW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for the serial pattern detector: config latch, FSM, match
// counter and start/err/done handshake around seq_match_core.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  seq_det_ctrl_if.slave  bus
);
  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [3:0]         len_q, len_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic accept, shift_en, hit, reach;

  assign accept   = (state_q == ST_IDLE) && bus.start && len_legal(bus.len, MAX_LEN);
  assign shift_en = (state_q == ST_RUN) && bus.x_valid;
  assign reach    = hit && (target_q != '0) && ((cnt_q + CNT_W'(1)) == target_q);

  seq_match_core #(.MAX_LEN(MAX_LEN)) u_core (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    (shift_en),
    .x     (bus.x),
    .pat   (pat_q),
    .len   (len_q),
    .hit   (hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Abort wins over a target-reaching match in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN: begin
        if (bus.abort)  state_d = ST_IDLE;
        else if (reach) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.z         = hit;
    bus.busy      = (state_q == ST_RUN);
    bus.done      = (state_q == ST_DONE);
    bus.err       = err_q;
    bus.match_cnt = cnt_q;
  end

  always_comb begin
    pat_d    = pat_q;
    len_d    = len_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    err_d    = (state_q == ST_IDLE) && bus.start && !len_legal(bus.len, MAX_LEN);
    if (accept) begin
      pat_d    = bus.pat;
      len_d    = bus.len;
      target_d = bus.target;
      cnt_d    = '0;
    end else if (hit && !bus.abort && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q    <= '0;
      len_q    <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      pat_q    <= pat_d;
      len_q    <= len_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: overlap detection, target/done, rejected
// starts, valid gaps, abort priority, async reset and a full-length pattern.
module tb_seq_det_ctrl;
  import seq_det_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  seq_det_ctrl_if #(.MAX_LEN(8), .CNT_W(8)) bus ();

  seq_det_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t);
    bus.start  = 1'b1;
    bus.pat    = p;
    bus.len    = l;
    bus.target = t;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic bit_step(input string tag, input logic xb, input logic v, input logic exp_z);
    bus.x       = xb;
    bus.x_valid = v;
    #1;
    check(tag, 32'(bus.z), 32'(exp_z));
    tick();
    bus.x_valid = 1'b0;
  endtask

  logic [7:0] strm;
  logic [7:0] zexp;
  logic [7:0] p8;

  initial begin
    bus.start = 0; bus.abort = 0; bus.pat = '0; bus.len = '0;
    bus.target = '0; bus.x = 0; bus.x_valid = 0;

    #2;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err",  32'(bus.err),  32'd0);
    check("rst_cnt",  32'(bus.match_cnt), 32'd0);
    check("rst_z",    32'(bus.z),    32'd0);
    #10 reset = 1'b1;
    tick();

    // Overlapping 101 over 1,0,1,0,1,1,0,1 with unlimited target
    strm = 8'b1010_1101;
    zexp = 8'b0010_1001;
    do_start(8'b101, 4'd3, 8'd0);
    check("t1_busy", 32'(bus.busy), 32'd1);
    check("t1_cnt0", 32'(bus.match_cnt), 32'd0);
    for (int i = 0; i < 8; i++) bit_step($sformatf("t1_z%0d", i + 1), strm[7-i], 1'b1, zexp[7-i]);
    check("t1_cnt",  32'(bus.match_cnt), 32'd3);
    check("t1_busy2", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    check("t1_idle", 32'(bus.busy), 32'd0);
    check("t1_hold", 32'(bus.match_cnt), 32'd3);

    // Same stream, target=2: done after bit 5, rest ignored
    do_start(8'b101, 4'd3, 8'd2);
    for (int i = 0; i < 5; i++) bit_step($sformatf("t2_z%0d", i + 1), strm[7-i], 1'b1, zexp[7-i]);
    check("t2_done", 32'(bus.done), 32'd1);
    check("t2_busy", 32'(bus.busy), 32'd0);
    check("t2_cnt",  32'(bus.match_cnt), 32'd2);
    for (int i = 5; i < 8; i++) begin
      bit_step($sformatf("t2_z%0d", i + 1), strm[7-i], 1'b1, 1'b0);
      check($sformatf("t2_nodone%0d", i + 1), 32'(bus.done), 32'd0);
    end
    check("t2_cnt2", 32'(bus.match_cnt), 32'd2);
    check("t2_idle", 32'(bus.busy), 32'd0);

    // Illegal lengths rejected with an err pulse
    do_start(8'b101, 4'd0, 8'd0);
    check("t3_err0",  32'(bus.err),  32'd1);
    check("t3_busy0", 32'(bus.busy), 32'd0);
    tick();
    check("t3_errc",  32'(bus.err),  32'd0);
    do_start(8'b101, 4'd9, 8'd0);
    check("t3_err9",  32'(bus.err),  32'd1);
    check("t3_busy9", 32'(bus.busy), 32'd0);
    check("t3_cnt",   32'(bus.match_cnt), 32'd2);
    tick();
    check("t3_busyl", 32'(bus.busy), 32'd0);

    // Valid gap between bits 1 and 2; a start during RUN is ignored
    do_start(8'b101, 4'd3, 8'd0);
    bit_step("t4_b1", 1'b1, 1'b1, 1'b0);
    bit_step("t4_g1", 1'b1, 1'b0, 1'b0);
    bus.start = 1'b1; bus.pat = 8'h00; bus.len = 4'd1; bus.target = 8'd1;
    bit_step("t4_g2", 1'b0, 1'b0, 1'b0);
    bus.start = 1'b0;
    bit_step("t4_g3", 1'b1, 1'b0, 1'b0);
    check("t4_err", 32'(bus.err), 32'd0);
    bit_step("t4_b2", 1'b0, 1'b1, 1'b0);
    bit_step("t4_b3", 1'b1, 1'b1, 1'b1);
    check("t4_cnt", 32'(bus.match_cnt), 32'd1);

    // Abort coincident with a match: z shown, no count, no done
    bit_step("t5_b4", 1'b0, 1'b1, 1'b0);
    bus.abort = 1'b1;
    bit_step("t5_b5", 1'b1, 1'b1, 1'b1);
    bus.abort = 1'b0;
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_cnt",  32'(bus.match_cnt), 32'd1);
    check("t5_done", 32'(bus.done), 32'd0);
    tick();
    check("t5_done2", 32'(bus.done), 32'd0);

    // Asynchronous reset mid-run, then a fresh run with target=1
    do_start(8'b101, 4'd3, 8'd0);
    bit_step("t6_b1", 1'b1, 1'b1, 1'b0);
    bit_step("t6_b2", 1'b0, 1'b1, 1'b0);
    bit_step("t6_b3", 1'b1, 1'b1, 1'b1);
    check("t6_cnt1", 32'(bus.match_cnt), 32'd1);
    check("t6_busy1", 32'(bus.busy), 32'd1);
    #3 reset = 1'b0;
    #1;
    check("t6_rbusy", 32'(bus.busy), 32'd0);
    check("t6_rcnt",  32'(bus.match_cnt), 32'd0);
    #2 reset = 1'b1;
    tick();
    check("t6_nodone", 32'(bus.done), 32'd0);
    do_start(8'b11, 4'd2, 8'd1);
    check("t6_busy2", 32'(bus.busy), 32'd1);
    bit_step("t6_c1", 1'b1, 1'b1, 1'b0);
    bit_step("t6_c2", 1'b1, 1'b1, 1'b1);
    check("t6_done", 32'(bus.done), 32'd1);
    check("t6_cnt",  32'(bus.match_cnt), 32'd1);
    tick();
    check("t6_done0", 32'(bus.done), 32'd0);
    check("t6_idle",  32'(bus.busy), 32'd0);

    // Full-length pattern: only the 8th bit can complete the window
    p8 = 8'hA5;
    do_start(p8, 4'd8, 8'd1);
    for (int i = 0; i < 8; i++) bit_step($sformatf("t7_z%0d", i + 1), p8[7-i], 1'b1, (i == 7));
    check("t7_done", 32'(bus.done), 32'd1);
    check("t7_cnt",  32'(bus.match_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
